// File: rtl/spi_pkg.sv
// rtl/spi_pkg.sv - shared constants, state encoding and word-mask helper for the SPI target
package spi_pkg;

    localparam int WORD_W     = 16;
    localparam int DATA_LEN_W = 4;

    localparam int CPOL_BIT = 1;
    localparam int CPHA_BIT = 0;

    localparam logic [1:0] MODE0 = 2'b00;
    localparam logic [1:0] MODE1 = 2'b01;
    localparam logic [1:0] MODE2 = 2'b10;
    localparam logic [1:0] MODE3 = 2'b11;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        SHIFT = 2'b01
    } spi_state_t;

    // Ones in bits [len:0], zeros above.
    function automatic logic [WORD_W-1:0] len_mask(input logic [DATA_LEN_W-1:0] len);
        return {WORD_W{1'b1}} >> (DATA_LEN_W'(WORD_W - 1) - len);
    endfunction

endpackage

// File: rtl/spi_sync_edge.sv
// rtl/spi_sync_edge.sv - multi-stage pin synchronizer with rise/fall pulses
module spi_sync_edge #(
    parameter int   SYNC_STAGES = 2,
    parameter logic RESET_VAL   = 1'b0
) (
    input  logic i_Clk,
    input  logic i_Rst_L,
    input  logic i_pin,
    output logic o_sync,
    output logic o_rise,
    output logic o_fall
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   prev_q;

    always_ff @(posedge i_Clk or negedge i_Rst_L) begin
        if (!i_Rst_L) begin
            sync_q <= {SYNC_STAGES{RESET_VAL}};
            prev_q <= RESET_VAL;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], i_pin};
            prev_q <= sync_q[SYNC_STAGES-1];
        end
    end

    assign o_sync = sync_q[SYNC_STAGES-1];
    assign o_rise = o_sync & ~prev_q;
    assign o_fall = ~o_sync & prev_q;

endmodule

// File: rtl/spi_slave_multi_word.sv
// rtl/spi_slave_multi_word.sv - oversampled SPI target, 1-16 bit words, all modes; SPI_SLAVE_MISO_TRISTATE_EN adds o_SPI_MISO_En
module spi_slave_multi_word
    import spi_pkg::*;
#(
    parameter int MAX_WORDS_PER_CS = 4,
    parameter int SYNC_STAGES      = 2
) (
    input  logic                                  i_Clk,
    input  logic                                  i_Rst_L,
    input  logic [1:0]                            i_spi_mode,
    input  logic [DATA_LEN_W-1:0]                 i_data_length,
    input  logic [WORD_W-1:0]                     i_TX_Data,
    input  logic                                  i_TX_DV,
    output logic                                  o_TX_Ready,
    output logic                                  o_TX_Underrun,
    output logic                                  o_RX_DV,
    output logic [WORD_W-1:0]                     o_RX_Data,
    output logic [$clog2(MAX_WORDS_PER_CS+1)-1:0] o_RX_Count,
    output logic                                  o_CS_Active,
    input  logic                                  i_SPI_Clk,
    input  logic                                  i_SPI_CS_n,
    input  logic                                  i_SPI_MOSI,
`ifdef SPI_SLAVE_MISO_TRISTATE_EN
    output logic                                  o_SPI_MISO_En,
`endif
    output logic                                  o_SPI_MISO
);

    localparam int CNT_W = $clog2(MAX_WORDS_PER_CS + 1);

    spi_state_t             state;
    logic [1:0]             mode_q;
    logic [DATA_LEN_W-1:0]  len_q;
    logic [DATA_LEN_W-1:0]  bit_cnt;
    logic [WORD_W-2:0]      rx_shift;
    logic [WORD_W-1:0]      tx_shift;
    logic [WORD_W-1:0]      tx_hold;
    logic                   tx_full;
    logic [SYNC_STAGES-1:0] mosi_sync;

    logic sclk_s, sclk_rise, sclk_fall;
    logic cs_s, cs_rise, cs_fall;
    logic mosi_s, cpha, sclk_edge, lead_e, trail_e, sample_e, shift_e;
    logic last_bit, word_start, tx_take;
    logic [WORD_W-1:0] next_word, rx_full;

    spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sclk_sync (
        .i_Clk(i_Clk), .i_Rst_L(i_Rst_L), .i_pin(i_SPI_Clk),
        .o_sync(sclk_s), .o_rise(sclk_rise), .o_fall(sclk_fall)
    );

    spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_cs_sync (
        .i_Clk(i_Clk), .i_Rst_L(i_Rst_L), .i_pin(i_SPI_CS_n),
        .o_sync(cs_s), .o_rise(cs_rise), .o_fall(cs_fall)
    );

    always_ff @(posedge i_Clk or negedge i_Rst_L) begin
        if (!i_Rst_L) mosi_sync <= '0;
        else          mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], i_SPI_MOSI};
    end
    assign mosi_s = mosi_sync[SYNC_STAGES-1];

    // Leading edge is the one that moves SCLK away from its CPOL idle level.
    always_comb begin
        cpha       = mode_q[CPHA_BIT];
        sclk_edge  = sclk_rise | sclk_fall;
        lead_e     = sclk_edge && (sclk_s != mode_q[CPOL_BIT]);
        trail_e    = sclk_edge && (sclk_s == mode_q[CPOL_BIT]);
        sample_e   = (state == SHIFT) && (cpha ? trail_e : lead_e);
        shift_e    = (state == SHIFT) && (cpha ? lead_e : trail_e);
        last_bit   = sample_e && (bit_cnt == len_q);
        word_start = ((state == IDLE) && cs_fall && !i_spi_mode[CPHA_BIT])
                   || (!cpha && last_bit && !cs_rise)
                   || (cpha && shift_e && (bit_cnt == '0));
        tx_take    = i_TX_DV && !tx_full;
        next_word  = tx_full ? tx_hold : (tx_take ? i_TX_Data : '0);
        rx_full    = {rx_shift, mosi_s};
    end

    always_ff @(posedge i_Clk or negedge i_Rst_L) begin
        if (!i_Rst_L) begin
            state         <= IDLE;
            mode_q        <= '0;
            len_q         <= '0;
            bit_cnt       <= '0;
            rx_shift      <= '0;
            tx_shift      <= '0;
            tx_hold       <= '0;
            tx_full       <= 1'b0;
            o_RX_DV       <= 1'b0;
            o_RX_Data     <= '0;
            o_RX_Count    <= '0;
            o_TX_Underrun <= 1'b0;
        end else begin
            o_RX_DV       <= 1'b0;
            o_TX_Underrun <= word_start && !tx_full && !tx_take;

            // A word taken in the same cycle as a word start bypasses the holding register.
            if (word_start)   tx_full <= 1'b0;
            else if (tx_take) begin
                tx_hold <= i_TX_Data;
                tx_full <= 1'b1;
            end

            case (state)
                IDLE: begin
                    if (cs_fall) begin
                        state      <= SHIFT;
                        mode_q     <= i_spi_mode;
                        len_q      <= i_data_length;
                        bit_cnt    <= '0;
                        rx_shift   <= '0;
                        o_RX_Count <= '0;
                        tx_shift   <= i_spi_mode[CPHA_BIT] ? '0 : next_word;
                    end
                end
                SHIFT: begin
                    if (sample_e) begin
                        rx_shift <= rx_full[WORD_W-2:0];
                        if (bit_cnt == len_q) begin
                            bit_cnt   <= '0;
                            o_RX_DV   <= 1'b1;
                            o_RX_Data <= rx_full & len_mask(len_q);
                            if (o_RX_Count != CNT_W'(MAX_WORDS_PER_CS))
                                o_RX_Count <= o_RX_Count + CNT_W'(1);
                        end else begin
                            bit_cnt <= bit_cnt + DATA_LEN_W'(1);
                        end
                    end
                    // With CPHA=0 the trailing edge right after a reload must not shift the fresh MSB out.
                    if (word_start)
                        tx_shift <= next_word;
                    else if (shift_e && (cpha || (bit_cnt != '0)))
                        tx_shift <= tx_shift << 1;
                    if (cs_rise) begin
                        state    <= IDLE;
                        tx_shift <= '0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign o_TX_Ready  = ~tx_full;
    assign o_CS_Active = ~cs_s;
    assign o_SPI_MISO  = o_CS_Active && (state == SHIFT) && tx_shift[len_q];

`ifdef SPI_SLAVE_MISO_TRISTATE_EN
    assign o_SPI_MISO_En = o_CS_Active;
`endif

endmodule

// File: tb/tb_spi_slave_multi_word.sv
// tb/tb_spi_slave_multi_word.sv - directed and randomized SPI frames checked against a word-level model
module tb_spi_slave_multi_word;

    localparam int MAXW = 4;

    logic        clk = 1'b0;
    logic        i_Rst_L;
    logic [1:0]  i_spi_mode;
    logic [3:0]  i_data_length;
    logic [15:0] i_TX_Data;
    logic        i_TX_DV;
    logic        o_TX_Ready, o_TX_Underrun, o_RX_DV, o_CS_Active, o_SPI_MISO;
    logic [15:0] o_RX_Data;
    logic [2:0]  o_RX_Count;
    logic        i_SPI_Clk, i_SPI_CS_n, i_SPI_MOSI;
`ifdef SPI_SLAVE_MISO_TRISTATE_EN
    logic        o_SPI_MISO_En;
`endif

    spi_slave_multi_word #(.MAX_WORDS_PER_CS(MAXW), .SYNC_STAGES(2)) dut (
        .i_Clk(clk), .i_Rst_L(i_Rst_L), .i_spi_mode(i_spi_mode), .i_data_length(i_data_length),
        .i_TX_Data(i_TX_Data), .i_TX_DV(i_TX_DV), .o_TX_Ready(o_TX_Ready),
        .o_TX_Underrun(o_TX_Underrun), .o_RX_DV(o_RX_DV), .o_RX_Data(o_RX_Data),
        .o_RX_Count(o_RX_Count), .o_CS_Active(o_CS_Active), .i_SPI_Clk(i_SPI_Clk),
        .i_SPI_CS_n(i_SPI_CS_n), .i_SPI_MOSI(i_SPI_MOSI),
`ifdef SPI_SLAVE_MISO_TRISTATE_EN
        .o_SPI_MISO_En(o_SPI_MISO_En),
`endif
        .o_SPI_MISO(o_SPI_MISO)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;

    logic [15:0] rx_got[$];
    int          und_cnt = 0;
    logic [15:0] feed_q[$];
    int          feed_idx = 0;
    logic [15:0] mosi_q[$];
    logic [15:0] exp_tx[$];
    logic [15:0] miso_q[$];

    always @(negedge clk) begin
        if (o_RX_DV) rx_got.push_back(o_RX_Data);
        if (o_TX_Underrun) und_cnt++;
    end

    initial begin
        i_TX_DV = 1'b0;
        i_TX_Data = '0;
        forever begin
            @(negedge clk);
            if (feed_idx < feed_q.size() && o_TX_Ready && i_Rst_L) begin
                i_TX_Data = feed_q[feed_idx];
                i_TX_DV = 1'b1;
                feed_idx++;
                @(negedge clk);
                i_TX_DV = 1'b0;
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Bit-level SPI master; records the MISO word it sampled for each word sent.
    task automatic spi_frame(input logic [1:0] mode, input logic [3:0] len, input int n, input int max_bits);
        logic cpol, cpha;
        logic [15:0] w, m;
        int sent;
        cpol = mode[1];
        cpha = mode[0];
        i_spi_mode = mode;
        i_data_length = len;
        i_SPI_Clk = cpol;
        #80 i_SPI_CS_n = 1'b0;
        #80;
        sent = 0;
        for (int k = 0; k < n; k++) begin
            w = mosi_q[k];
            m = '0;
            for (int b = int'(len); b >= 0; b--) begin
                if (max_bits >= 0 && sent == max_bits) break;
                if (!cpha) begin
                    i_SPI_MOSI = w[b];
                    #80 m[b] = o_SPI_MISO;
                    i_SPI_Clk = ~cpol;
                    #80 i_SPI_Clk = cpol;
                end else begin
                    i_SPI_Clk = ~cpol;
                    #1 i_SPI_MOSI = w[b];
                    #79 m[b] = o_SPI_MISO;
                    i_SPI_Clk = cpol;
                    #80;
                end
                sent++;
            end
            miso_q.push_back(m);
        end
        #80 i_SPI_CS_n = 1'b1;
        #200;
    endtask

    task automatic do_frame(input string tag, input logic [1:0] mode, input logic [3:0] len,
                            input int n, input bit with_tx, input int max_bits, output int und);
        int rx_base, und_base, exp_cnt;
        logic [15:0] mask, exp_m;
        mask = 16'((32'd1 << (int'(len) + 1)) - 1);
        rx_base = rx_got.size();
        und_base = und_cnt;
        miso_q.delete();
        if (with_tx) begin
            for (int k = 0; k < n; k++) feed_q.push_back(exp_tx[k]);
            #100;
        end
        spi_frame(mode, len, n, max_bits);
        und = und_cnt - und_base;
        if (max_bits < 0) begin
            check({tag, " rx_count"}, 32'(rx_got.size() - rx_base), 32'(n));
            for (int k = 0; k < n && rx_base + k < rx_got.size(); k++)
                check({tag, " rx_data"}, 32'(rx_got[rx_base + k]), 32'(mosi_q[k] & mask));
            for (int k = 0; k < n; k++) begin
                exp_m = with_tx ? (exp_tx[k] & mask) : 16'h0;
                check({tag, " miso"}, 32'(miso_q[k]), 32'(exp_m));
            end
            exp_cnt = (n > MAXW) ? MAXW : n;
            check({tag, " o_RX_Count"}, 32'(o_RX_Count), 32'(exp_cnt));
        end else begin
            check({tag, " no rx_dv on abort"}, 32'(rx_got.size() - rx_base), 32'd0);
        end
        check({tag, " cs_active idle"}, 32'(o_CS_Active), 32'd0);
        check({tag, " miso idle"}, 32'(o_SPI_MISO), 32'd0);
    endtask

    initial begin
        int und, rb;
        logic [1:0] rmode;
        logic [3:0] rlen;
        int rn;

        i_Rst_L = 1'b0;
        i_spi_mode = 2'b00;
        i_data_length = 4'd7;
        i_SPI_Clk = 1'b0;
        i_SPI_CS_n = 1'b1;
        i_SPI_MOSI = 1'b0;
        #22;
        check("reset o_TX_Ready", 32'(o_TX_Ready), 32'd1);
        check("reset o_RX_DV", 32'(o_RX_DV), 32'd0);
        check("reset o_RX_Data", 32'(o_RX_Data), 32'd0);
        check("reset o_RX_Count", 32'(o_RX_Count), 32'd0);
        check("reset o_TX_Underrun", 32'(o_TX_Underrun), 32'd0);
        check("reset o_CS_Active", 32'(o_CS_Active), 32'd0);
        check("reset o_SPI_MISO", 32'(o_SPI_MISO), 32'd0);
`ifdef SPI_SLAVE_MISO_TRISTATE_EN
        check("reset o_SPI_MISO_En", 32'(o_SPI_MISO_En), 32'd0);
`endif
        i_Rst_L = 1'b1;
        #40;

        // Mode 0, 8-bit, A5 in, 3C out.
        mosi_q = '{16'h00A5};
        exp_tx = '{16'h003C};
        do_frame("m0_a5", 2'b00, 4'd7, 1, 1'b1, -1, und);

        // Mode 3, three 16-bit words with refills between words.
        mosi_q = '{16'h1234, 16'hBEEF, 16'h0F0F};
        exp_tx = '{16'hC3A5, 16'h7E81, 16'h0FF0};
        do_frame("m3_three", 2'b11, 4'd15, 3, 1'b1, -1, und);
        check("m3_three underruns", 32'(und), 32'd0);
        check("m3_three tx_ready", 32'(o_TX_Ready), 32'd1);

        // Mode 1, nothing loaded.
        mosi_q = '{16'h0081, 16'h007E};
        do_frame("m1_underrun", 2'b01, 4'd7, 2, 1'b0, -1, und);
        check("m1_underrun pulses", 32'(und), 32'd2);

        // Mode 2, aborted after 9 bits, then a clean frame.
        mosi_q = '{16'hFFFF};
        do_frame("m2_abort", 2'b10, 4'd15, 1, 1'b0, 9, und);
        mosi_q = '{16'h5555};
        do_frame("m2_after", 2'b10, 4'd15, 1, 1'b0, -1, und);

        // Six words, count saturates then clears on next CS fall.
        mosi_q = '{16'h0011, 16'h0022, 16'h0033, 16'h0044, 16'h0055, 16'h0066};
        do_frame("m0_sat", 2'b00, 4'd7, 6, 1'b0, -1, und);
        i_SPI_CS_n = 1'b0;
        #100;
        check("count clears on cs fall", 32'(o_RX_Count), 32'd0);
        check("cs_active in frame", 32'(o_CS_Active), 32'd1);
`ifdef SPI_SLAVE_MISO_TRISTATE_EN
        check("miso_en in frame", 32'(o_SPI_MISO_En), 32'd1);
`endif
        i_SPI_CS_n = 1'b1;
        #200;

        // Asynchronous reset in the middle of a word.
        rb = rx_got.size();
        i_spi_mode = 2'b00;
        i_data_length = 4'd15;
        i_SPI_Clk = 1'b0;
        i_SPI_CS_n = 1'b0;
        #80;
        for (int b = 0; b < 5; b++) begin
            i_SPI_MOSI = 1'b1;
            #80 i_SPI_Clk = 1'b1;
            #80 i_SPI_Clk = 1'b0;
        end
        i_Rst_L = 1'b0;
        #20;
        check("midrst o_TX_Ready", 32'(o_TX_Ready), 32'd1);
        check("midrst o_RX_Count", 32'(o_RX_Count), 32'd0);
        check("midrst o_CS_Active", 32'(o_CS_Active), 32'd0);
        check("midrst o_SPI_MISO", 32'(o_SPI_MISO), 32'd0);
`ifdef SPI_SLAVE_MISO_TRISTATE_EN
        check("midrst o_SPI_MISO_En", 32'(o_SPI_MISO_En), 32'd0);
`endif
        i_SPI_CS_n = 1'b1;
        #100 i_Rst_L = 1'b1;
        #200;
        check("midrst no rx_dv", 32'(rx_got.size() - rb), 32'd0);
        check("midrst o_RX_Data", 32'(o_RX_Data), 32'd0);

        // Randomized frames against the word-level model.
        for (int r = 0; r < 8; r++) begin
            rmode = 2'($urandom_range(0, 3));
            rlen = 4'($urandom_range(0, 15));
            rn = $urandom_range(1, 3);
            mosi_q.delete();
            exp_tx.delete();
            for (int k = 0; k < rn; k++) begin
                mosi_q.push_back(16'($urandom));
                exp_tx.push_back(16'($urandom));
            end
            do_frame($sformatf("rand%0d", r), rmode, rlen, rn, 1'b1, -1, und);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/spi_slave_multi_word.md
Name: spi_slave_multi_word

Overview:
- SPI target (peripheral) block; the far end of the team's multi-CS SPI master, used for on-chip loopback and for external-controller access to the register file.
- Oversamples the SPI pins (SCLK, CS_n, MOSI) in the system clock domain and supports all four SPI modes.
- Word length is programmable from 1 to 16 bits, MSB first.
- Presents received words as single-cycle valid pulses and accepts transmit words through a valid/ready holding register.

Parameters:
- MAX_WORDS_PER_CS, 4, saturation limit of the per-frame received-word counter.
- SYNC_STAGES, 2, flop stages on each SPI input pin (minimum 2).

Ports:
- i_Clk  in  1  system clock; must be at least 8x SCLK.
- i_Rst_L  in  1  reset. Asynchronous assert, active-low. Synchronous release is handled outside the block.
- i_spi_mode  in  2  {CPOL,CPHA}.
- i_data_length  in  4  bits per word minus 1 (0 = 1 bit, 15 = 16 bits).
- i_TX_Data  in  16  next word to send, right-justified.
- i_TX_DV  in  1  TX word valid.
- o_TX_Ready  out  1  holding register empty.
- o_TX_Underrun  out  1  one-cycle pulse: a word started with no TX data loaded.
- o_RX_DV  out  1  one-cycle pulse: o_RX_Data is valid.
- o_RX_Data  out  16  received word, right-justified, upper bits zero.
- o_RX_Count  out  $clog2(MAX_WORDS_PER_CS+1)  words received in the current frame.
- o_CS_Active  out  1  synchronized chip-select is active.
- i_SPI_Clk  in  1  SCLK pin.
- i_SPI_CS_n  in  1  chip-select pin, active-low.
- i_SPI_MOSI  in  1  MOSI pin.
- o_SPI_MISO  out  1  MISO pin.

Behaviour:
- Reset values:
  - All outputs are 0, except o_TX_Ready=1.
  - State = IDLE; TX holding register empty; synchronizer flops set to SCLK=0, CS_n=1.
- Pin handling: SCLK, CS_n and MOSI each pass through SYNC_STAGES flops. Edge detection is done on the synchronized SCLK and CS_n.
- Leading/trailing edges: the leading edge is rising when CPOL=0 and falling when CPOL=1.
  - CPHA=0: sample on the leading edge, shift on the trailing edge.
  - CPHA=1: shift on the leading edge, sample on the trailing edge.
- State machine:
  - IDLE: wait for CS falling. On CS falling:
    - latch i_spi_mode and i_data_length (these are ignored until the next CS falling);
    - clear the bit counter and o_RX_Count;
    - load the TX word;
    - go to SHIFT.
  - SHIFT:
    - On each sample edge, shift the synchronized MOSI into the RX shifter.
    - When bit count == length, o_RX_DV pulses on the next i_Clk cycle (within 4 i_Clk cycles of the pin edge). o_RX_Count then increments, saturating at MAX_WORDS_PER_CS.
    - The bit counter reloads for the next word, and the TX word reloads on the next shift edge (CPHA=1) or immediately (CPHA=0).
  - CS rising in any state: return to IDLE the following cycle.
    - A partial RX word is discarded (no o_RX_DV).
    - A partially sent TX word is dropped.
    - o_RX_Count holds its value until the next CS falling.
- TX load:
  - A word is taken when i_TX_DV && o_TX_Ready; o_TX_Ready drops the next cycle.
  - o_TX_Ready reasserts when the word moves into the shifter.
  - If the holding register is empty at a word start: send all zeros and pulse o_TX_Underrun once.
- MISO drive:
  - CPHA=0: bit N-1 appears at CS falling, before the first sample edge.
  - CPHA=1: bit N-1 appears on the first leading edge.
  - MISO is driven 0 while CS is inactive.
- Simultaneous events:
  - TX load in the same cycle as a word start: the new word is used and there is no underrun.
  - CS rising in the same cycle as a final-bit sample: the word completes and o_RX_DV fires.
- Asynchronous reset mid-frame: immediate return to reset values; no o_RX_DV.

Optional Feature:
- Macro: SPI_SLAVE_MISO_TRISTATE_EN.
- Defined: adds port o_SPI_MISO_En (out, 1). It is 1 only while o_CS_Active=1 and 0 otherwise, so the pad can tristate for a shared MISO bus. o_SPI_MISO keeps its defined behaviour.
- Undefined: no o_SPI_MISO_En port; MISO is always driven, 0 when inactive.

Decomposition:
- Package spi_pkg holds:
  - SPI mode constants (MODE0..MODE3, CPOL/CPHA bit indices);
  - state encodings IDLE=2'b00, SHIFT=2'b01;
  - WORD_W=16 and DATA_LEN_W=4.
- One sub-module, spi_sync_edge: a SYNC_STAGES synchronizer with rise/fall pulse outputs. It is instantiated for SCLK and CS_n; MOSI uses its synchronized output only.

Test Plan:
- Mode 0, length 7 (8-bit), master sends 8'hA5, TX preloaded 16'h003C -> o_RX_Data=16'h00A5 with one o_RX_DV pulse; MISO bits 0,0,1,1,1,1,0,0; o_RX_Count=1.
- Mode 3, length 15, three back-to-back words 16'h1234/16'hBEEF/16'h0F0F in one CS frame -> three o_RX_DV pulses in order; o_RX_Count=3; o_TX_Ready handshake refills between words.
- Mode 1, no TX loaded, 2 words sent -> MISO all 0; two o_TX_Underrun pulses.
- Mode 2, length 15, CS raised after 9 bits -> no o_RX_DV; state IDLE; the next frame receives 16'h5555 cleanly.
- MAX_WORDS_PER_CS=4, 6 words in one frame -> six o_RX_DV pulses; o_RX_Count saturates at 4; it clears on the next CS falling.
- i_Rst_L low mid-word, then released -> all outputs at reset values; o_TX_Ready=1; no spurious o_RX_DV. With SPI_SLAVE_MISO_TRISTATE_EN defined: o_SPI_MISO_En=0 during reset and 1 only inside the CS frame.
